mcp3008_scanner: RTL
====================

# mcp3008_scanner

Autonomous SPI master for the MCP3008 8-channel 10-bit ADC that round-robins over a channel mask and emits each conversion as a stream beat. It sits directly upstream of the motor-control logic, which consumes accel, current and battery samples. It replaces bit-banged CS/DIN/AD_CLK sequencing with a self-timed frame engine driven by the 50 MHz system clock.

## Interface
- CLK_DIV, 27: clk cycles per AD_CLK half-period; legal range 1..4095.
- CH_MASK, 8'hFF: channel enable bitmask; bit n enables channel n.
- CS_HIGH, 16: clk cycles CS is held high between frames; legal range 1..65535.
- clk  input  1  system clock, 50 MHz.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  scan run request; sampled between frames only.
- AD_CLK  output  1  SPI SCLK to MCP3008, mode 0,0, idles low.
- CS  output  1  MCP3008 chip select, active-low.
- DIN  output  1  command bits to MCP3008.
- DOUT  input  1  conversion data from MCP3008.
- stm_sample_out_tdata  output  10  conversion result, B9..B0.
- stm_sample_out_tid  output  3  channel number of tdata.
- stm_sample_out_tvalid  output  1  beat valid.
- stm_sample_out_tready  input  1  consumer ready.
- scan_done  output  1  one-cycle pulse after the highest enabled channel's beat is loaded.
- overrun_count  output  8  saturating count of beats overwritten before acceptance.

## Operation
- States: IDLE, FRAME, GAP.
- IDLE: CS=1, AD_CLK=0, DIN=0. Go to FRAME when enable=1 and CH_MASK!=0. If CH_MASK==0, stay in IDLE permanently.
- Channel pointer: after reset, points at the lowest enabled channel. After each frame, advances to the next enabled channel upward, wrapping 7->0.
- FRAME has 17 AD_CLK rising edges:
  - DIN bits in order: start=1, SGL=1, D2, D1, D0 (pointer bits), then DIN=0 for the rest of the frame.
  - Rising edges 1-5 clock in the command. Edge 6 is the sample period. Edge 7 returns the null bit, which is ignored.
  - Edges 8..17 shift in B9..B0, MSB first, into a 10-bit shift register.
- End of frame loads the output register: tdata=shift value, tid=pointer.
  - If tvalid=1 and tready=0 at the load cycle, the old beat is overwritten and overrun_count increments, saturating at 255.
  - scan_done pulses if the pointer was the highest enabled channel.
- GAP: CS=1 for CS_HIGH cycles.
  - Then go to FRAME if enable=1, else IDLE.
  - enable deassertion during FRAME never truncates the frame.
- Stream handshake:
  - tvalid stays 1 until a cycle with tready=1; tvalid clears on the next edge unless a new beat is loaded that same edge.
  - A load and an acceptance on the same edge: new beat is valid, no overrun counted.
- rst in any state, including mid-frame, forces every output to its reset value on the next edge and aborts the frame; no beat is emitted.

## Timing
- Reset values: CS=1, AD_CLK=0, DIN=0, tdata=0, tid=0, tvalid=0, scan_done=0, overrun_count=0.
- Let D=CLK_DIV and t0 the edge where CS falls. DIN=start bit is driven at t0.
- AD_CLK rising edge k (k=1..17) occurs at t0+(2k-1)D; falling edge k occurs at t0+2kD.
- DIN updates on falling edges 1..5: SGL, D2, D1, D0, then 0.
- DOUT is sampled on the clk edge where AD_CLK rises, at edges k=8..17.
- At t0+34D, on one edge: AD_CLK falls for the 17th time, CS rises, the beat loads, and tvalid=1.
- Next CS fall is at t0+34D+CS_HIGH. Frame period is 34D+CS_HIGH cycles; default is 934 cycles (18.68 us).
- Latency from the B0 sample to tvalid is D cycles.
- No combinational path from tready or DOUT to any output.

## Test plan
- Reset, D=2, CH_MASK=8'h20, enable=1, tready=1, ADC model returns 0x2A5 on ch5 -> DIN sequence 1,1,1,0,1; tdata=0x2A5, tid=5; CS low for exactly 68 cycles; scan_done pulses each frame.
- CH_MASK=8'h25, models return ch0=0x001, ch2=0x3FF, ch5=0x155 -> tid order 0,2,5,0,2,5 with matching tdata; scan_done only with the tid=5 beats.
- tready held 0 for 300 frames -> tvalid stays 1; tdata and tid track the newest frame; overrun_count=255 (saturated); tready=1 then accepts exactly one beat.
- enable dropped at frame edge 3 -> frame completes and beat is emitted, CS stays 1 after GAP, state IDLE; raising enable again resumes at the next enabled channel.
- rst asserted at AD_CLK edge 10 -> next cycle all outputs at reset values, no beat; after release the first frame targets the lowest enabled channel.
- CH_MASK=0, enable=1 for 10000 cycles -> CS=1 and AD_CLK=0 throughout; tvalid never asserts.

Source files
------------

// File: rtl/mcp3008_scanner.sv
// rtl/mcp3008_scanner.sv - MCP3008 round-robin SPI scanner emitting one stream beat per conversion
module mcp3008_scanner #(
  parameter int unsigned CLK_DIV = 27,
  parameter logic [7:0]  CH_MASK = 8'hFF,
  parameter int unsigned CS_HIGH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       AD_CLK,
  output logic       CS,
  output logic       DIN,
  input  logic       DOUT,
  output logic [9:0] stm_sample_out_tdata,
  output logic [2:0] stm_sample_out_tid,
  output logic       stm_sample_out_tvalid,
  input  logic       stm_sample_out_tready,
  output logic       scan_done,
  output logic [7:0] overrun_count
);

  typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

  // Next enabled channel strictly above cur, wrapping 7->0; cur itself if it is the only one.
  function automatic logic [2:0] next_ch(input logic [2:0] cur);
    logic [2:0] r;
    r = cur;
    for (int i = 7; i >= 1; i--) begin
      if (CH_MASK[3'(int'(cur) + i)]) r = 3'(int'(cur) + i);
    end
    return r;
  endfunction

  function automatic logic [2:0] high_ch();
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (CH_MASK[i]) r = 3'(i);
    end
    return r;
  endfunction

  localparam logic [2:0]  LOW_CH   = next_ch(3'd7);
  localparam logic [2:0]  HIGH_CH  = high_ch();
  localparam logic [11:0] DIV_LAST = 12'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(CS_HIGH - 1);

  state_t      state, state_nxt;
  logic [11:0] div_cnt;
  logic [5:0]  half_cnt;   // index of the current AD_CLK half-period, 0..33
  logic [15:0] gap_cnt;
  logic [2:0]  ptr;
  logic [9:0]  shift;
  logic        tick;
  logic        frame_end;
  logic        start;

  assign tick      = (state == FRAME) && (div_cnt == DIV_LAST);
  assign frame_end = tick && (half_cnt == 6'd33);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; start marks the edge where CS falls.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (enable && (CH_MASK != 8'h00)) begin
          state_nxt = FRAME;
          start     = 1'b1;
        end
      end
      FRAME: begin
        if (frame_end) state_nxt = GAP;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (enable) begin
            state_nxt = FRAME;
            start     = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame engine, sample register and stream handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      CS                    <= 1'b1;
      AD_CLK                <= 1'b0;
      DIN                   <= 1'b0;
      div_cnt               <= 12'd0;
      half_cnt              <= 6'd0;
      gap_cnt               <= 16'd0;
      ptr                   <= LOW_CH;
      shift                 <= 10'd0;
      stm_sample_out_tdata  <= 10'd0;
      stm_sample_out_tid    <= 3'd0;
      stm_sample_out_tvalid <= 1'b0;
      scan_done             <= 1'b0;
      overrun_count         <= 8'd0;
    end else begin
      scan_done <= 1'b0;
      if (stm_sample_out_tvalid && stm_sample_out_tready) stm_sample_out_tvalid <= 1'b0;

      if (start) begin
        CS       <= 1'b0;
        DIN      <= 1'b1;
        div_cnt  <= 12'd0;
        half_cnt <= 6'd0;
      end else if (state == FRAME) begin
        if (tick) begin
          div_cnt  <= 12'd0;
          half_cnt <= half_cnt + 6'd1;
          if (!half_cnt[0]) begin
            // Rising edge k = half_cnt/2 + 1; edges 8..17 carry B9..B0.
            AD_CLK <= 1'b1;
            if (half_cnt >= 6'd14) shift <= {shift[8:0], DOUT};
          end else begin
            // Falling edge k = (half_cnt+1)/2; edges 1..5 advance the command bits.
            AD_CLK <= 1'b0;
            case (half_cnt)
              6'd1:    DIN <= 1'b1;
              6'd3:    DIN <= ptr[2];
              6'd5:    DIN <= ptr[1];
              6'd7:    DIN <= ptr[0];
              6'd9:    DIN <= 1'b0;
              default: ;
            endcase
          end
          if (frame_end) begin
            CS                    <= 1'b1;
            gap_cnt               <= 16'd0;
            stm_sample_out_tdata  <= shift;
            stm_sample_out_tid    <= ptr;
            stm_sample_out_tvalid <= 1'b1;
            scan_done             <= (ptr == HIGH_CH);
            ptr                   <= next_ch(ptr);
            if (stm_sample_out_tvalid && !stm_sample_out_tready && (overrun_count != 8'hFF))
              overrun_count <= overrun_count + 8'd1;
          end
        end else begin
          div_cnt <= div_cnt + 12'd1;
        end
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt + 16'd1;
      end
    end
  end

endmodule
